// File: rtl/tcam_lookup_ctrl_if.sv
// Request/response handshake bundle between a client and tcam_lookup_ctrl.
// The client drives the master modport; the controller takes the slave modport.
interface tcam_lookup_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_key;
    logic [15:0] req_mask;
    logic [3:0]  req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [3:0]  rsp_addr;

    modport master (
        output req_valid, req_write, req_key, req_mask, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit, rsp_addr
    );

    modport slave (
        input  req_valid, req_write, req_key, req_mask, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_hit, rsp_addr
    );
endinterface

// File: rtl/tcam_lookup_ctrl.sv
// Request-side controller for a 16-entry TCAM: registered pin drive, a two-stage
// lookup pipe, credit-based response FIFO and lookup/hit statistics.
module tcam_lookup_ctrl #(
    parameter int RSP_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    tcam_lookup_ctrl_if.slave   bus,
    output logic [15:0]         tcam_data,
    output logic [15:0]         tcam_dontcare_mask,
    output logic [3:0]          tcam_write_address,
    output logic                tcam_write_readN,
    output logic                tcam_resetN,
    input  logic [3:0]          tcam_found_address,
    input  logic                tcam_hit,
    output logic [15:0]         lookup_count,
    output logic [15:0]         hit_count
);
    localparam int PW = $clog2(RSP_DEPTH);

    logic [15:0]   r_tcam_data;
    logic [15:0]   r_tcam_mask;
    logic [3:0]    r_tcam_waddr;
    logic          r_tcam_wr_n;
    logic          r_s1_lookup;
    logic          r_s2_lookup;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic [4:0]    r_mem [RSP_DEPTH];
    logic [15:0]   r_lookup_count;
    logic [15:0]   r_hit_count;

    logic [PW+1:0] w_outstanding;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_rsp_valid;
    logic [4:0]    w_head;

    // Every lookup past S1 holds a FIFO slot in reserve, so a push never finds the FIFO full.
    assign w_outstanding = (PW+2)'(r_count) + (PW+2)'(r_s1_lookup) + (PW+2)'(r_s2_lookup);
    assign bus.req_ready = (w_outstanding < (PW+2)'(RSP_DEPTH));
    assign w_accept      = bus.req_valid & bus.req_ready;
    assign w_push        = r_s2_lookup;
    assign w_rsp_valid   = (r_count != '0);
    assign w_pop         = w_rsp_valid & bus.rsp_ready;
    assign w_head        = r_mem[r_rd_ptr];

    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_hit   = w_rsp_valid & w_head[4];
    assign bus.rsp_addr  = w_rsp_valid ? w_head[3:0] : 4'd0;

    assign tcam_data          = r_tcam_data;
    assign tcam_dontcare_mask = r_tcam_mask;
    assign tcam_write_address = r_tcam_waddr;
    assign tcam_write_readN   = r_tcam_wr_n;
    assign tcam_resetN        = ~reset;
    assign lookup_count       = r_lookup_count;
    assign hit_count          = r_hit_count;

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcam_data  <= '0;
            r_tcam_mask  <= '0;
            r_tcam_waddr <= '0;
            r_tcam_wr_n  <= 1'b0;
            r_s1_lookup  <= 1'b0;
            r_s2_lookup  <= 1'b0;
        end else begin
            r_s2_lookup <= r_s1_lookup;
            if (w_accept) begin
                r_tcam_data <= bus.req_key;
                r_tcam_wr_n <= bus.req_write;
                r_s1_lookup <= ~bus.req_write;
                if (bus.req_write) begin
                    r_tcam_mask  <= bus.req_mask;
                    r_tcam_waddr <= bus.req_addr;
                end
            end else begin
                r_tcam_wr_n <= 1'b0;
                r_s1_lookup <= 1'b0;
            end
        end
    end

    // NOTE: FIFO storage is deliberately left unreset; outputs are gated by rsp_valid instead.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {tcam_hit, tcam_hit ? tcam_found_address : 4'd0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_lookup_count <= '0;
            r_hit_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr       <= r_wr_ptr + PW'(1);
                r_lookup_count <= r_lookup_count + 16'd1;
                if (tcam_hit) begin
                    r_hit_count <= r_hit_count + 16'd1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// Bench for tcam_lookup_ctrl: directed literal cases plus randomized traffic checked
// every cycle against a transaction-level reference (ordered queue of expected responses).
module tb_tcam_lookup_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] tcam_data;
    logic [15:0] tcam_dontcare_mask;
    logic [3:0]  tcam_write_address;
    logic        tcam_write_readN;
    logic        tcam_resetN;
    logic [3:0]  tcam_found_address;
    logic        tcam_hit;
    logic [15:0] lookup_count;
    logic [15:0] hit_count;

    tcam_lookup_ctrl_if bus ();

    tcam_lookup_ctrl #(.RSP_DEPTH(DEPTH)) dut (
        .clk                (clk),
        .reset              (reset),
        .bus                (bus),
        .tcam_data          (tcam_data),
        .tcam_dontcare_mask (tcam_dontcare_mask),
        .tcam_write_address (tcam_write_address),
        .tcam_write_readN   (tcam_write_readN),
        .tcam_resetN        (tcam_resetN),
        .tcam_found_address (tcam_found_address),
        .tcam_hit           (tcam_hit),
        .lookup_count       (lookup_count),
        .hit_count          (hit_count)
    );

    always #5 clk = ~clk;

    // TCAM device: registered compare, lowest-numbered matching entry wins.
    logic [15:0] t_key  [16];
    logic [15:0] t_mask [16];
    always @(posedge clk or negedge tcam_resetN) begin
        if (!tcam_resetN) begin
            for (int i = 0; i < 16; i++) begin
                t_key[i]  <= '0;
                t_mask[i] <= '0;
            end
            tcam_hit           <= 1'b0;
            tcam_found_address <= '0;
        end else if (tcam_write_readN) begin
            t_key[tcam_write_address]  <= tcam_data;
            t_mask[tcam_write_address] <= tcam_dontcare_mask;
        end else begin
            tcam_hit           <= 1'b0;
            tcam_found_address <= '0;
            for (int i = 15; i >= 0; i--) begin
                if (((t_key[i] ^ tcam_data) & ~t_mask[i]) == 16'd0) begin
                    tcam_hit           <= 1'b1;
                    tcam_found_address <= 4'(i);
                end
            end
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int stalls = 0;
    int dut_pops = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: contents table updated at write accept, responses queued at lookup accept.
    typedef struct {
        int         due;
        bit         hit;
        logic [3:0] addr;
    } exp_t;

    exp_t        q[$];
    logic [15:0] ref_key  [16];
    logic [15:0] ref_mask [16];
    int          cyc = 0;
    logic [15:0] exp_lc;
    logic [15:0] exp_hc;

    function automatic exp_t ref_lookup(input logic [15:0] key);
        exp_t r;
        r.due = 0; r.hit = 1'b0; r.addr = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!r.hit && (((ref_key[i] ^ key) & ~ref_mask[i]) == 16'd0)) begin
                r.hit  = 1'b1;
                r.addr = 4'(i);
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        q.delete();
        for (int i = 0; i < 16; i++) begin
            ref_key[i]  = '0;
            ref_mask[i] = '0;
        end
        exp_lc = '0;
        exp_hc = '0;
    endtask

    initial begin
        bit   ready_pre;
        bit   valid_pre;
        exp_t e;
        forever begin
            @(posedge clk);
            if (reset) begin
                model_clear();
                continue;
            end
            ready_pre = (q.size() < DEPTH);
            valid_pre = (q.size() > 0) && (q[0].due <= cyc);
            if (bus.rsp_valid && bus.rsp_ready) dut_pops++;
            if (valid_pre && bus.rsp_ready) void'(q.pop_front());
            cyc++;
            foreach (q[i]) begin
                if (q[i].due == cyc) begin
                    exp_lc++;
                    if (q[i].hit) exp_hc++;
                end
            end
            if (bus.req_valid && ready_pre) begin
                if (bus.req_write) begin
                    ref_key[bus.req_addr]  = bus.req_key;
                    ref_mask[bus.req_addr] = bus.req_mask;
                end else begin
                    e = ref_lookup(bus.req_key);
                    e.due = cyc + 2;
                    q.push_back(e);
                end
            end
        end
    end

    // Per-cycle comparison against the reference, away from the active edge.
    initial begin
        bit ev;
        forever begin
            @(negedge clk);
            if (!reset) begin
                ev = (q.size() > 0) && (q[0].due <= cyc);
                check("req_ready", bus.req_ready, (q.size() < DEPTH));
                check("rsp_valid", bus.rsp_valid, ev);
                if (ev) begin
                    check("rsp_hit", bus.rsp_hit, q[0].hit);
                    check("rsp_addr", bus.rsp_addr, q[0].addr);
                end
                check("lookup_count", lookup_count, exp_lc);
                check("hit_count", hit_count, exp_hc);
            end
        end
    end

    // Offers one request and returns on the negedge after the accepting edge.
    task automatic send(input bit wr, input logic [15:0] key, input logic [15:0] mask,
                        input logic [3:0] addr);
        int waited = 0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_key   = key;
        bus.req_mask  = mask;
        bus.req_addr  = addr;
        while (!bus.req_ready) begin
            if (waited == 200) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: req_ready still 0 after %0d cycles, expected 1", waited);
                break;
            end
            if (waited >= 8) bus.rsp_ready = 1'b1;
            @(negedge clk);
            waited++;
            stalls++;
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic lookup_expect(input string nm, input logic [15:0] key, input bit eh,
                                 input logic [3:0] ea, input logic [15:0] elc,
                                 input logic [15:0] ehc);
        send(1'b0, key, 16'h0, 4'h0);
        check({nm, "_valid_e0"}, bus.rsp_valid, 1'b0);
        @(negedge clk);
        check({nm, "_valid_e1"}, bus.rsp_valid, 1'b0);
        @(negedge clk);
        check({nm, "_valid_e2"}, bus.rsp_valid, 1'b1);
        check({nm, "_hit"}, bus.rsp_hit, eh);
        check({nm, "_addr"}, bus.rsp_addr, ea);
        check({nm, "_lookup_count"}, lookup_count, elc);
        check({nm, "_hit_count"}, hit_count, ehc);
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        model_clear();
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [15:0] pick_key();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'hA5A5;
            2:       return 16'h1234;
            3:       return 16'hBEEF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] pick_mask();
        case ($urandom_range(0, 4))
            0:       return 16'h0000;
            1:       return 16'h000F;
            2:       return 16'h00FF;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int pops0;
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_key   = '0;
        bus.req_mask  = '0;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b1;
        model_clear();

        repeat (2) @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_hit", bus.rsp_hit, 1'b0);
        check("rst_rsp_addr", bus.rsp_addr, 4'd0);
        check("rst_tcam_data", tcam_data, 16'd0);
        check("rst_tcam_mask", tcam_dontcare_mask, 16'd0);
        check("rst_tcam_waddr", tcam_write_address, 4'd0);
        check("rst_tcam_wr", tcam_write_readN, 1'b0);
        check("rst_tcam_resetN", tcam_resetN, 1'b0);
        check("rst_lookup_count", lookup_count, 16'd0);
        check("rst_hit_count", hit_count, 16'd0);
        #2 reset = 1'b0;
        #1 check("rel_tcam_resetN", tcam_resetN, 1'b1);
        @(negedge clk);
        check("rel_req_ready", bus.req_ready, 1'b1);

        lookup_expect("default", 16'h0000, 1'b1, 4'd0, 16'd1, 16'd1);
        send(1'b1, 16'hA5A5, 16'h00FF, 4'd5);
        lookup_expect("prog_hit", 16'hA512, 1'b1, 4'd5, 16'd2, 16'd2);
        lookup_expect("prog_miss", 16'h1234, 1'b0, 4'd0, 16'd3, 16'd2);
        send(1'b1, 16'hFFFF, 16'hFFFF, 4'd3);
        send(1'b1, 16'hFFFF, 16'hFFFF, 4'd9);
        lookup_expect("priority", 16'hBEEF, 1'b1, 4'd3, 16'd4, 16'd3);
        @(negedge clk);

        // Streaming: 32 lookups back to back from a clean reset.
        reset_dut();
        bus.rsp_ready = 1'b1;
        stalls = 0;
        for (int i = 0; i < 32; i++) begin
            send(1'b0, ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom), 16'h0, 4'h0);
        end
        check("stream_stalls", stalls, 0);
        repeat (4) @(negedge clk);
        check("stream_lookup_count", lookup_count, 16'd32);

        // Backpressure: 6 lookups offered against a stalled response port.
        bus.rsp_ready = 1'b0;
        pops0 = dut_pops;
        acc = 0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_key   = 16'($urandom);
        for (int c = 0; c < 10; c++) begin
            if (bus.req_ready) acc++;
            @(negedge clk);
            bus.req_key = pick_key();
        end
        bus.req_valid = 1'b0;
        check("bp_accepted", acc, 4);
        check("bp_req_ready_low", bus.req_ready, 1'b0);
        bus.rsp_ready = 1'b1;
        send(1'b0, 16'h0000, 16'h0, 4'h0);
        send(1'b0, 16'hA5A5, 16'h0, 4'h0);
        repeat (8) @(negedge clk);
        check("bp_responses", dut_pops - pops0, 6);

        // Randomized mixed traffic.
        for (int it = 0; it < 400; it++) begin
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 8) begin
                if ($urandom_range(0, 3) == 0)
                    send(1'b1, pick_key(), pick_mask(), 4'($urandom_range(0, 15)));
                else
                    send(1'b0, pick_key(), 16'($urandom), 4'($urandom_range(0, 15)));
            end else begin
                @(negedge clk);
            end
        end
        bus.rsp_ready = 1'b1;
        repeat (10) @(negedge clk);

        // Asynchronous reset with 2 lookups in flight and 2 queued.
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 16'h0000, 16'h0, 4'h0);
        check("pre_rst_rsp_valid", bus.rsp_valid, 1'b1);
        #2 reset = 1'b1;
        model_clear();
        #1;
        check("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("mid_rst_lookup_count", lookup_count, 16'd0);
        check("mid_rst_hit_count", hit_count, 16'd0);
        check("mid_rst_tcam_resetN", tcam_resetN, 1'b0);
        check("mid_rst_req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check("post_rst_tcam_resetN", tcam_resetN, 1'b1);
        bus.rsp_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_no_stale", bus.rsp_valid, 1'b0);
        check("post_rst_lookup_count", lookup_count, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
